vote_collect: RTL and testbench
===============================

VOTE_COLLECT -- requirements
Module: vote_collect

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16, giving the maximum COLLECT duration in clock cycles (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: a level sampled in IDLE that opens a voting round.
REQ-005 The module SHALL have ports yes1, yes2, yes3, input, 1 bit each: judge N casts a "pass" vote.
REQ-006 The module SHALL have ports no1, no2, no3, input, 1 bit each: judge N casts a "fail" vote.
REQ-007 The module SHALL have ports in1, in2, in3, output, 1 bit each: latched votes (1 = pass) that drive the downstream 3-input judge.
REQ-008 The module SHALL have port valid, output, 1 bit: in1..in3 are final and stable.
REQ-009 The module SHALL have port ack, input, 1 bit: the consumer has taken the result.
REQ-010 The module SHALL have port busy, output, 1 bit: a round is in progress (COLLECT).
REQ-011 The module SHALL have port timed_out, output, 1 bit: the round ended by timeout, not by all three votes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-013 IDLE -> COLLECT SHALL occur on an edge with start=1; on that edge the cast flags, in1..in3, timed_out and the 8-bit cycle counter SHALL all clear to 0.
REQ-014 In COLLECT, judge N's first edge with exactly one of yesN/noN high SHALL set castN=1 and inN=yesN.
- Later presses by judge N SHALL be ignored (first vote locks).
REQ-015 If yesN and noN are both high on the same edge, that edge SHALL be ignored for judge N; castN stays 0.
REQ-016 COLLECT -> DONE SHALL occur on the edge where all three castN are 1 after that edge's updates; timed_out=0.
- Votes arriving on the same edge SHALL all be captured.
REQ-017 The counter SHALL increment every COLLECT cycle.
- On the edge where counter == TIMEOUT-1 and not all votes are cast, the state SHALL go to DONE with timed_out=1.
- Uncast judges SHALL keep inN=0.
- Votes registered on that same edge SHALL count; if they complete the set, timed_out=0.
REQ-018 busy SHALL equal (state==COLLECT); valid SHALL equal (state==DONE); both are registered-state decodes with no combinational path from inputs.
REQ-019 In DONE, in1..in3 and timed_out SHALL hold constant; DONE -> IDLE SHALL occur on an edge with ack=1.
REQ-020 valid SHALL go low the cycle after ack is sampled; in1..in3 and timed_out SHALL retain their values in IDLE until the next start.
REQ-021 start outside IDLE, and ack outside DONE, SHALL be ignored.
REQ-022 The shortest round SHALL be 1 COLLECT cycle (all votes on the first COLLECT edge); the longest SHALL be exactly TIMEOUT COLLECT cycles.
REQ-023 If start is held high, a new round SHALL begin on the edge after returning to IDLE (one IDLE cycle minimum).

Reset
REQ-024 On an edge with rst=1, the state SHALL go to IDLE and in1..in3, valid, busy, timed_out, the cast flags and the counter SHALL go to 0, regardless of state.
REQ-025 rst SHALL take priority over start, ack and votes on the same edge; reset mid-COLLECT SHALL discard the round with no valid pulse.

Verification
REQ-026 start; then yes1, no2 and yes3 on successive edges -> busy=1 for 3 cycles, then valid=1, {in1,in2,in3}=101, timed_out=0; ack -> valid=0 next cycle.
REQ-027 start; then yes1, yes2 and yes3 together on the first COLLECT edge -> exactly 1 busy cycle, {in1,in2,in3}=111, timed_out=0.
REQ-028 TIMEOUT=16; start; only yes2 cast -> busy stays high for exactly 16 cycles, then {in1,in2,in3}=010, timed_out=1.
REQ-029 yes1 and no1 together, then no1 alone, then yes1 -> in1=0 (the first clean vote locks); cast1 is not set by the conflicting edge.
REQ-030 rst on the 3rd COLLECT cycle after two votes -> all outputs 0 next cycle, valid never asserts; a subsequent start runs a clean round.
REQ-031 Sweep all 8 vote combinations as complete rounds with ack -> in1..in3 match the combination every round, and start/ack glitches in the wrong state have no effect.

Source files
------------

// File: rtl/vote_collect_if.sv
// Bundle of the vote inputs, the latched result and the round handshake for vote_collect.
// The collector attaches through the slave modport and the vote source through master.
interface vote_collect_if;
    logic start;
    logic yes1, yes2, yes3;
    logic no1, no2, no3;
    logic ack;
    logic in1, in2, in3;
    logic valid;
    logic busy;
    logic timed_out;

    modport slave (
        input  start, yes1, yes2, yes3, no1, no2, no3, ack,
        output in1, in2, in3, valid, busy, timed_out
    );

    modport master (
        output start, yes1, yes2, yes3, no1, no2, no3, ack,
        input  in1, in2, in3, valid, busy, timed_out
    );
endinterface

// File: rtl/vote_collect.sv
// Collects one locked vote from each of three judges, or gives up after TIMEOUT cycles,
// and holds the result for a downstream consumer until it is acknowledged.
module vote_collect #(
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst,
    vote_collect_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] cast_q, cast_d;
    logic [2:0] vote_q, vote_d;
    logic       timed_out_q, timed_out_d;
    logic [7:0] cnt_q, cnt_d;

    logic [2:0] yes_v, no_v;

    // Bit 0 is judge 1 throughout.
    assign yes_v = {bus.yes3, bus.yes2, bus.yes1};
    assign no_v  = {bus.no3, bus.no2, bus.no1};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        cast_d      = cast_q;
        vote_d      = vote_q;
        timed_out_d = timed_out_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = COLLECT;
                    cast_d      = '0;
                    vote_d      = '0;
                    timed_out_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            COLLECT: begin
                cnt_d = cnt_q + 8'd1;
                // A judge's first clean (exactly one of yes/no) edge locks its vote.
                for (int i = 0; i < 3; i++) begin
                    if (!cast_q[i] && (yes_v[i] ^ no_v[i])) begin
                        cast_d[i] = 1'b1;
                        vote_d[i] = yes_v[i];
                    end
                end
                if (&cast_d) begin
                    state_d     = DONE;
                    timed_out_d = 1'b0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cast_q      <= '0;
            vote_q      <= '0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cast_q      <= cast_d;
            vote_q      <= vote_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in1       = vote_q[0];
    assign bus.in2       = vote_q[1];
    assign bus.in3       = vote_q[2];
    assign bus.timed_out = timed_out_q;
    assign bus.busy      = (state_q == COLLECT);
    assign bus.valid     = (state_q == DONE);

endmodule

// File: tb/tb_vote_collect.sv
// Directed self-checking bench for vote_collect; status vectors are {valid,busy,timed_out,in1,in2,in3}.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same moment.
module tb_vote_collect;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    vote_collect_if vif ();

    vote_collect #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // y/n are ordered {judge1, judge2, judge3} to match the status vector.
    task automatic votes(input logic [2:0] y, input logic [2:0] n);
        {vif.yes1, vif.yes2, vif.yes3} = y;
        {vif.no1, vif.no2, vif.no3}    = n;
    endtask

    function automatic logic [5:0] status;
        return {vif.valid, vif.busy, vif.timed_out, vif.in1, vif.in2, vif.in3};
    endfunction

    initial begin
        int n;
        vif.start = 1'b0;
        vif.ack   = 1'b0;
        votes(3'b000, 3'b000);
        rst = 1'b1;
        tick;
        tick;
        check("reset", status(), 6'b000000);
        rst = 1'b0;

        // Votes on successive edges: 1 pass, 2 fail, 3 pass.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        check("seq_busy1", status(), 6'b010000);
        votes(3'b100, 3'b000); tick;
        check("seq_busy2", status(), 6'b010100);
        votes(3'b000, 3'b010); tick;
        check("seq_busy3", status(), 6'b010100);
        votes(3'b001, 3'b000); tick; votes(3'b000, 3'b000);
        check("seq_done", status(), 6'b100101);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;
        check("seq_ack_idle", status(), 6'b000101);

        // All votes on the first COLLECT edge.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        check("fast_busy", status(), 6'b010000);
        votes(3'b111, 3'b000); tick; votes(3'b000, 3'b000);
        check("fast_done", status(), 6'b100111);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;
        check("fast_idle", status(), 6'b000111);

        // Timeout with only judge 2 voting.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        n = 0;
        while (vif.busy && n < 100) begin
            n++;
            if (n == 1) votes(3'b010, 3'b000);
            else        votes(3'b000, 3'b000);
            tick;
        end
        check("to_busy_cycles", n, 16);
        check("to_done", status(), 6'b101010);
        votes(3'b111, 3'b000); tick; votes(3'b000, 3'b000);
        check("to_hold", status(), 6'b101010);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;
        check("to_idle", status(), 6'b001010);

        // Conflicting edge ignored; first clean vote (fail) locks judge 1.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        votes(3'b100, 3'b100); tick;
        check("conf_edge", status(), 6'b010000);
        votes(3'b000, 3'b100); tick;
        check("conf_no1", status(), 6'b010000);
        votes(3'b100, 3'b000); tick;
        check("conf_yes1_ignored", status(), 6'b010000);
        votes(3'b011, 3'b000); tick; votes(3'b000, 3'b000);
        check("conf_done", status(), 6'b100011);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;

        // Reset on the third COLLECT cycle beats a completing vote.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        votes(3'b100, 3'b000); tick;
        votes(3'b000, 3'b010); tick;
        check("rst_pre", status(), 6'b010100);
        votes(3'b001, 3'b000); rst = 1'b1; tick; rst = 1'b0; votes(3'b000, 3'b000);
        check("rst_mid", status(), 6'b000000);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rst_no_valid", status(), 6'b000000);
        end
        vif.start = 1'b1; tick; vif.start = 1'b0;
        check("rst_clean_busy", status(), 6'b010000);
        votes(3'b100, 3'b011); tick; votes(3'b000, 3'b000);
        check("rst_clean_done", status(), 6'b100100);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;

        // Sweep every vote combination with start/ack glitches in the wrong states.
        for (int c = 0; c < 8; c++) begin
            logic [2:0] v;
            v = 3'(c);
            vif.start = 1'b1; vif.ack = 1'b1; tick; vif.ack = 1'b0;
            check("sweep_busy", status(), 6'b010000);
            vif.ack = 1'b1; votes(v, ~v); tick; vif.ack = 1'b0; votes(3'b000, 3'b000);
            check("sweep_done", status(), {3'b100, v});
            tick;
            check("sweep_start_in_done", status(), {3'b100, v});
            vif.start = 1'b0; vif.ack = 1'b1; tick; vif.ack = 1'b0;
            check("sweep_idle", status(), {3'b000, v});
        end

        // start held high: one IDLE cycle, then a new round begins.
        vif.start = 1'b1; tick;
        votes(3'b111, 3'b000); tick; votes(3'b000, 3'b000);
        check("hold_done", status(), 6'b100111);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;
        check("hold_idle_gap", status(), 6'b000111);
        tick; vif.start = 1'b0;
        check("hold_restart", status(), 6'b010000);
        votes(3'b000, 3'b111); tick; votes(3'b000, 3'b000);
        check("hold_done2", status(), 6'b100000);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;

        // Set completed on the timeout edge itself: timed_out stays 0.
        vif.start = 1'b1; tick; vif.start = 1'b0;
        for (int i = 0; i < 15; i++) tick;
        check("last_edge_busy", status(), 6'b010000);
        votes(3'b111, 3'b000); tick; votes(3'b000, 3'b000);
        check("last_edge_done", status(), 6'b100111);
        vif.ack = 1'b1; tick; vif.ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
